// File: rtl/riscv_biu_arb.sv
// Two-port (imem/dmem) arbiter in front of a single BIU; holds the grant for a whole burst.
// Optional macro BIU_ARB_RR_EN selects round-robin arbitration instead of fixed D-over-I priority.
package riscv_biu_arb_pkg;
  typedef logic [2:0] biu_size_t;
  typedef logic [2:0] biu_prot_t;
  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } biu_type_t;
endpackage

module riscv_biu_arb
  import riscv_biu_arb_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PLEN        = XLEN,
  parameter int BIUTAG_SIZE = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   i_stb_i,
  output logic                   i_stb_ack_o,
  input  logic [PLEN-1:0]        i_adri_i,
  input  biu_size_t              i_size_i,
  input  biu_type_t              i_type_i,
  input  biu_prot_t              i_prot_i,
  input  logic                   i_we_i,
  input  logic                   i_lock_i,
  input  logic [XLEN-1:0]        i_d_i,
  input  logic [BIUTAG_SIZE-1:0] i_tagi_i,
  output logic [XLEN-1:0]        i_q_o,
  output logic                   i_ack_o,
  output logic                   i_err_o,
  output logic                   i_d_ack_o,

  input  logic                   d_stb_i,
  output logic                   d_stb_ack_o,
  input  logic [PLEN-1:0]        d_adri_i,
  input  biu_size_t              d_size_i,
  input  biu_type_t              d_type_i,
  input  biu_prot_t              d_prot_i,
  input  logic                   d_we_i,
  input  logic                   d_lock_i,
  input  logic [XLEN-1:0]        d_d_i,
  input  logic [BIUTAG_SIZE-1:0] d_tagi_i,
  output logic [XLEN-1:0]        d_q_o,
  output logic                   d_ack_o,
  output logic                   d_err_o,
  output logic                   d_d_ack_o,

  output logic                   biu_stb_o,
  input  logic                   biu_stb_ack_i,
  input  logic                   biu_d_ack_i,
  output logic [PLEN-1:0]        biu_adri_o,
  output biu_size_t              biu_size_o,
  output biu_type_t              biu_type_o,
  output biu_prot_t              biu_prot_o,
  output logic                   biu_we_o,
  output logic                   biu_lock_o,
  output logic [XLEN-1:0]        biu_d_o,
  output logic [BIUTAG_SIZE-1:0] biu_tagi_o,
  input  logic [XLEN-1:0]        biu_q_i,
  input  logic                   biu_ack_i,
  input  logic                   biu_err_i,

  output logic [1:0]             gnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;      // one-hot {D,I}
  logic [4:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] arb_gnt;

  logic       own_stb, own_lock;
  biu_type_t  own_type;
  logic       in_addr, in_data, beat_evt, last_beat;

  function automatic logic [4:0] burst_len(input biu_type_t t);
    logic [4:0] len;
    unique case (t)
      WRAP4,  INCR4:  len = 5'd4;
      WRAP8,  INCR8:  len = 5'd8;
      WRAP16, INCR16: len = 5'd16;
      default:        len = 5'd1;
    endcase
    return len;
  endfunction

`ifdef BIU_ARB_RR_EN
  logic last_owner_q, last_owner_d;  // 1 = D won last

  always_comb begin
    arb_gnt = 2'b00;
    if (d_stb_i && i_stb_i) arb_gnt = last_owner_q ? 2'b01 : 2'b10;
    else if (d_stb_i)       arb_gnt = 2'b10;
    else if (i_stb_i)       arb_gnt = 2'b01;
  end

  assign last_owner_d = (|owner_d) ? owner_d[1] : last_owner_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) last_owner_q <= 1'b1;
    else         last_owner_q <= last_owner_d;
  end
`else
  always_comb begin
    arb_gnt = 2'b00;
    if (d_stb_i)      arb_gnt = 2'b10;
    else if (i_stb_i) arb_gnt = 2'b01;
  end
`endif

  assign own_stb   = owner_q[1] ? d_stb_i  : (owner_q[0] & i_stb_i);
  assign own_lock  = owner_q[1] ? d_lock_i : (owner_q[0] & i_lock_i);
  assign own_type  = owner_q[1] ? d_type_i : i_type_i;

  assign in_addr   = (state_q == ST_ADDR);
  assign in_data   = (state_q == ST_DATA);
  assign beat_evt  = in_data & (biu_ack_i | biu_err_i);
  assign last_beat = beat_evt & (biu_err_i | (beat_cnt_q == 5'd1));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|arb_gnt) begin
          state_d = ST_ADDR;
          owner_d = arb_gnt;
        end
      end
      ST_ADDR: begin
        if (!own_stb) begin
          state_d = ST_IDLE;
          owner_d = 2'b00;
        end else if (biu_stb_ack_i) begin
          state_d    = ST_DATA;
          beat_cnt_d = burst_len(own_type);
        end
      end
      ST_DATA: begin
        if (beat_evt) beat_cnt_d = beat_cnt_q - 5'd1;
        if (last_beat) begin
          beat_cnt_d = 5'd0;
          if (own_lock) begin
            state_d = ST_ADDR;
          end else if (|arb_gnt) begin
            state_d = ST_ADDR;
            owner_d = arb_gnt;
          end else begin
            state_d = ST_IDLE;
            owner_d = 2'b00;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        owner_d    = 2'b00;
        beat_cnt_d = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      owner_q    <= 2'b00;
      beat_cnt_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    biu_stb_o   = 1'b0;
    biu_adri_o  = '0;
    biu_size_o  = '0;
    biu_type_o  = SINGLE;
    biu_prot_o  = '0;
    biu_we_o    = 1'b0;
    biu_lock_o  = 1'b0;
    biu_d_o     = '0;
    biu_tagi_o  = '0;
    i_stb_ack_o = 1'b0;
    i_ack_o     = 1'b0;
    i_err_o     = 1'b0;
    i_d_ack_o   = 1'b0;
    d_stb_ack_o = 1'b0;
    d_ack_o     = 1'b0;
    d_err_o     = 1'b0;
    d_d_ack_o   = 1'b0;
    i_q_o       = biu_q_i;
    d_q_o       = biu_q_i;

    if (state_q != ST_IDLE) begin
      biu_stb_o = in_addr & own_stb;
      if (owner_q[1]) begin
        biu_adri_o = d_adri_i;
        biu_size_o = d_size_i;
        biu_type_o = d_type_i;
        biu_prot_o = d_prot_i;
        biu_we_o   = d_we_i;
        biu_lock_o = d_lock_i;
        biu_d_o    = d_d_i;
        biu_tagi_o = d_tagi_i;
      end else begin
        biu_adri_o = i_adri_i;
        biu_size_o = i_size_i;
        biu_type_o = i_type_i;
        biu_prot_o = i_prot_i;
        biu_we_o   = i_we_i;
        biu_lock_o = i_lock_i;
        biu_d_o    = i_d_i;
        biu_tagi_o = i_tagi_i;
      end
      // Acks only ever reach the owner; the other port sees zeros.
      d_stb_ack_o = owner_q[1] & in_addr & own_stb & biu_stb_ack_i;
      i_stb_ack_o = owner_q[0] & in_addr & own_stb & biu_stb_ack_i;
      d_ack_o     = owner_q[1] & in_data & biu_ack_i;
      i_ack_o     = owner_q[0] & in_data & biu_ack_i;
      d_err_o     = owner_q[1] & in_data & biu_err_i;
      i_err_o     = owner_q[0] & in_data & biu_err_i;
      d_d_ack_o   = owner_q[1] & biu_d_ack_i;
      i_d_ack_o   = owner_q[0] & biu_d_ack_i;
    end
  end

  assign gnt_o = owner_q;

`ifndef SYNTHESIS
  // Stray beats outside DATA are dropped by the arbiter; flag them without stopping simulation.
  a_beat_outside_data: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (biu_ack_i || biu_err_i) |-> (state_q == ST_DATA))
    else $warning("biu ack/err outside DATA state ignored");
`endif

endmodule
